// File: rtl/crop_pkg.sv
// crop_pkg: shared types and constants for the crop controller.
package crop_pkg;

    // Width of every window coordinate and size field.
    localparam int COORD_W = 16;

    // Frame-level control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } crop_state_e;

    // Latched crop window.
    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } crop_cfg_t;

endpackage

// File: rtl/crop_out_reg.sv
// crop_out_reg: single-entry output register with valid/ready hold.
// A new pixel may be loaded whenever the register is empty or is being
// consumed in the same cycle, so continuous flow has no bubbles.
module crop_out_reg #(
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PIX_W-1:0] load_pixel,
    input  logic             load_sof,
    input  logic             load_eol,
    input  logic             load_eof,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] pixel_out,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             can_accept
);

    assign can_accept = !out_valid || out_ready;

    // Load on request, otherwise empty the register once downstream takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            pixel_out <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            pixel_out <= load_pixel;
            out_sof   <= load_sof;
            out_eol   <= load_eol;
            out_eof   <= load_eof;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/crop_ctrl.sv
// crop_ctrl: crops a raster-order frame to a configurable window.
// The window is only reconfigured between frames; pixels outside the
// window are accepted and dropped so the upstream raster keeps moving.
module crop_ctrl
    import crop_pkg::*;
#(
    parameter int IN_ROWS = 40,
    parameter int IN_COLS = 40,
    parameter int PIX_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [COORD_W-1:0] cfg_x1,
    input  logic [COORD_W-1:0] cfg_y1,
    input  logic [COORD_W-1:0] cfg_w,
    input  logic [COORD_W-1:0] cfg_h,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   pixel_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   pixel_out,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [COORD_W:0]   COLS_EXT = (COORD_W+1)'(IN_COLS);
    localparam logic [COORD_W:0]   ROWS_EXT = (COORD_W+1)'(IN_ROWS);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IN_COLS - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IN_ROWS - 1);

    crop_state_e        state;
    crop_cfg_t          cfg_q;
    crop_cfg_t          cfg_in;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;

    logic               cfg_fire;
    logic               cfg_bad;
    logic [COORD_W:0]   x_end_in;
    logic [COORD_W:0]   y_end_in;
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic               in_fire;
    logic               can_accept;
    logic               col_in;
    logic               row_in;
    logic               in_win;
    logic               last_pix;
    logic               pix_sof;
    logic               pix_eol;
    logic               pix_eof;

    assign cfg_in    = {cfg_x1, cfg_y1, cfg_w, cfg_h};
    assign cfg_ready = (state == ST_IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign busy      = (state != ST_IDLE);

    // Window end points are one bit wider so huge offsets cannot wrap into range.
    assign x_end_in = {1'b0, cfg_x1} + {1'b0, cfg_w};
    assign y_end_in = {1'b0, cfg_y1} + {1'b0, cfg_h};
    assign cfg_bad  = (cfg_w == '0) || (cfg_h == '0) ||
                      (x_end_in > COLS_EXT) || (y_end_in > ROWS_EXT);

    assign x_end    = {1'b0, cfg_q.x1} + {1'b0, cfg_q.w};
    assign y_end    = {1'b0, cfg_q.y1} + {1'b0, cfg_q.h};

    assign in_ready = (state == ST_RUN) && can_accept;
    assign in_fire  = in_valid && in_ready;

    assign col_in   = (col >= cfg_q.x1) && ({1'b0, col} < x_end);
    assign row_in   = (row >= cfg_q.y1) && ({1'b0, row} < y_end);
    assign in_win   = col_in && row_in;
    assign last_pix = (row == LAST_ROW) && (col == LAST_COL);

    assign pix_sof  = (row == cfg_q.y1) && (col == cfg_q.x1);
    assign pix_eol  = ({1'b0, col} == (x_end - 1'b1));
    assign pix_eof  = ({1'b0, row} == (y_end - 1'b1)) && pix_eol;

    // Frame FSM, window latch, raster counters and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cfg_q      <= '0;
            row        <= '0;
            col        <= '0;
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            cfg_q <= cfg_in;
                            row   <= '0;
                            col   <= '0;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        if (last_pix) begin
                            row   <= '0;
                            col   <= '0;
                            state <= ST_DRAIN;
                        end else if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    crop_out_reg #(
        .PIX_W(PIX_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (in_fire && in_win),
        .load_pixel(pixel_in),
        .load_sof  (pix_sof),
        .load_eol  (pix_eol),
        .load_eof  (pix_eof),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .pixel_out (pixel_out),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .can_accept(can_accept)
    );

endmodule
